// File: rtl/cam_pkg.sv
// Shared encodings for the CAM insert/delete controller: request ops, response status, FSM states.
package cam_pkg;

    typedef enum logic {
        OP_INSERT = 1'b0,
        OP_DELETE = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_FULL     = 2'd1,
        ST_DUP      = 2'd2,
        ST_NOTFOUND = 2'd3
    } status_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        WRITE  = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4
    } state_e;

    function automatic int mask_width(input int data_w, input int slice_w);
        return (data_w + slice_w - 1) / slice_w;
    endfunction

endpackage

// File: rtl/cam_free_enc.sv
// Lowest-index free entry finder over the occupancy bitmap.
// Latency: combinational. Backpressure: none.
// none_free flags a fully occupied bitmap; addr is 0 in that case.
module cam_free_enc #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic [(1<<ADDR_WIDTH)-1:0] bitmap,
    output logic [ADDR_WIDTH-1:0]      addr,
    output logic                       none_free
);

    localparam int ENTRIES = 1 << ADDR_WIDTH;

    // Scan downward so the last hit written is the lowest free index.
    always_comb begin
        addr      = '0;
        none_free = 1'b1;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!bitmap[i]) begin
                addr      = ADDR_WIDTH'(i);
                none_free = 1'b0;
            end
        end
    end

endmodule

// File: rtl/cam_insert_ctrl.sv
// Insert/delete sequencer for a CAM: lookup, write at lowest free slot or matched slot, respond.
// Latency: MATCH_LATENCY+1 lookup cycles, then 1 write + busy-bounded wait on writes, then 1 response cycle.
// Backpressure: one request in flight; req_ready is high only in IDLE, CAM busy stalls the response.
module cam_insert_ctrl
    import cam_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDR_WIDTH    = 5,
    parameter int SLICE_WIDTH   = 4,
    parameter int MATCH_LATENCY = 1
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           req_valid,
    output logic                                           req_ready,
    input  logic                                           req_op,
    input  logic [DATA_WIDTH-1:0]                          req_data,
    input  logic [(DATA_WIDTH+SLICE_WIDTH-1)/SLICE_WIDTH-1:0] req_mask,
    output logic                                           rsp_valid,
    output logic [1:0]                                     rsp_status,
    output logic [ADDR_WIDTH-1:0]                          rsp_addr,
    output logic [ADDR_WIDTH-1:0]                          cam_write_addr,
    output logic [DATA_WIDTH-1:0]                          cam_write_data,
    output logic [(DATA_WIDTH+SLICE_WIDTH-1)/SLICE_WIDTH-1:0] cam_select_mask,
    output logic                                           cam_write_delete,
    output logic                                           cam_write_enable,
    input  logic                                           cam_write_busy,
    output logic [DATA_WIDTH-1:0]                          cam_compare_data,
    input  logic                                           cam_match,
    input  logic [ADDR_WIDTH-1:0]                          cam_match_addr,
    output logic [ADDR_WIDTH:0]                            used_count,
    output logic                                           full,
    output logic                                           empty
);

    localparam int         MW       = mask_width(DATA_WIDTH, SLICE_WIDTH);
    localparam int         ENTRIES  = 1 << ADDR_WIDTH;
    localparam logic [2:0] LAT_LAST = 3'(MATCH_LATENCY);

    state_e                  state, state_nxt;
    logic [2:0]              lat_cnt;
    op_e                     op_q;
    logic [MW-1:0]           mask_q;
    logic [ENTRIES-1:0]      bitmap;
    logic                    wait_first;
    status_e                 rsp_status_q;

    logic                    lookup_done;
    logic                    dec_write;
    status_e                 dec_status;
    logic [ADDR_WIDTH-1:0]   dec_addr;
    logic [ADDR_WIDTH-1:0]   free_addr;
    logic                    none_free;

    cam_free_enc #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_free_enc (
        .bitmap    (bitmap),
        .addr      (free_addr),
        .none_free (none_free)
    );

    assign full       = (used_count == (ADDR_WIDTH+1)'(ENTRIES));
    assign empty      = (used_count == '0);
    assign req_ready  = (state == IDLE);
    assign rsp_valid  = (state == RESP);
    assign rsp_status = rsp_status_q;

    assign lookup_done = (state == LOOKUP) && (lat_cnt == LAT_LAST);

    // Decision on the sampled match result; only meaningful when lookup_done.
    always_comb begin
        dec_write  = 1'b0;
        dec_status = ST_OK;
        dec_addr   = '0;
        if (op_q == OP_INSERT) begin
            if (cam_match) begin
                dec_status = ST_DUP;
                dec_addr   = cam_match_addr;
            end else if (full || none_free) begin
                dec_status = ST_FULL;
            end else begin
                dec_write = 1'b1;
                dec_addr  = free_addr;
            end
        end else begin
            if (!cam_match) begin
                dec_status = ST_NOTFOUND;
            end else begin
                dec_write = 1'b1;
                dec_addr  = cam_match_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = LOOKUP;
            LOOKUP:  if (lookup_done) state_nxt = dec_write ? WRITE : RESP;
            WRITE:   state_nxt = WAIT;
            WAIT:    if (!wait_first && !cam_write_busy) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt          <= '0;
            op_q             <= OP_INSERT;
            mask_q           <= '0;
            bitmap           <= '0;
            used_count       <= '0;
            wait_first       <= 1'b0;
            rsp_status_q     <= ST_OK;
            rsp_addr         <= '0;
            cam_write_addr   <= '0;
            cam_write_data   <= '0;
            cam_select_mask  <= '0;
            cam_write_delete <= 1'b0;
            cam_write_enable <= 1'b0;
            cam_compare_data <= '0;
        end else begin
            cam_write_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q             <= op_e'(req_op);
                        mask_q           <= req_mask;
                        cam_compare_data <= req_data;
                        lat_cnt          <= '0;
                    end
                end
                LOOKUP: begin
                    lat_cnt <= lat_cnt + 3'd1;
                    if (lookup_done) begin
                        rsp_status_q <= dec_status;
                        rsp_addr     <= dec_addr;
                        if (dec_write) begin
                            cam_write_addr   <= dec_addr;
                            cam_write_data   <= cam_compare_data;
                            cam_select_mask  <= mask_q;
                            cam_write_delete <= (op_q == OP_DELETE);
                            cam_write_enable <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    wait_first <= 1'b1;
                    if (cam_write_delete) begin
                        bitmap[cam_write_addr] <= 1'b0;
                        if (!empty) used_count <= used_count - 1'b1;
                    end else begin
                        bitmap[cam_write_addr] <= 1'b1;
                        if (!full) used_count <= used_count + 1'b1;
                    end
                end
                WAIT: begin
                    wait_first <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_insert_ctrl.sv
// Directed table of insert/delete requests against a small behavioural CAM, plus a reset-during-wait sequence.
module tb_cam_insert_ctrl;

    localparam int DW = 16;
    localparam int AW = 2;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_op;
    logic [DW-1:0] req_data;
    logic [MW-1:0] req_mask;
    logic          rsp_valid;
    logic [1:0]    rsp_status;
    logic [AW-1:0] rsp_addr;
    logic [AW-1:0] cam_write_addr;
    logic [DW-1:0] cam_write_data;
    logic [MW-1:0] cam_select_mask;
    logic          cam_write_delete, cam_write_enable, cam_write_busy;
    logic [DW-1:0] cam_compare_data;
    logic          cam_match;
    logic [AW-1:0] cam_match_addr;
    logic [AW:0]   used_count;
    logic          full, empty;

    always #5 clk = ~clk;

    cam_insert_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLICE_WIDTH(4), .MATCH_LATENCY(1)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_data(req_data), .req_mask(req_mask),
        .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_addr(rsp_addr),
        .cam_write_addr(cam_write_addr), .cam_write_data(cam_write_data),
        .cam_select_mask(cam_select_mask), .cam_write_delete(cam_write_delete),
        .cam_write_enable(cam_write_enable), .cam_write_busy(cam_write_busy),
        .cam_compare_data(cam_compare_data), .cam_match(cam_match),
        .cam_match_addr(cam_match_addr), .used_count(used_count),
        .full(full), .empty(empty)
    );

    // Behavioural CAM: one-cycle registered match, two busy cycles after each write.
    logic [DW-1:0] key [4];
    logic [3:0]    vbit;
    logic [1:0]    busy_cnt;
    assign cam_write_busy = (busy_cnt != 2'd0);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            vbit <= '0; busy_cnt <= '0; cam_match <= 1'b0; cam_match_addr <= '0;
            for (int i = 0; i < 4; i++) key[i] <= '0;
        end else begin
            cam_match <= 1'b0; cam_match_addr <= '0;
            for (int i = 3; i >= 0; i--)
                if (vbit[i] && key[i] == cam_compare_data) begin
                    cam_match <= 1'b1; cam_match_addr <= 2'(i);
                end
            if (busy_cnt != 2'd0) busy_cnt <= busy_cnt - 2'd1;
            if (cam_write_enable) begin
                busy_cnt <= 2'd2;
                if (cam_write_delete) vbit[cam_write_addr] <= 1'b0;
                else begin
                    key[cam_write_addr]  <= cam_write_data;
                    vbit[cam_write_addr] <= 1'b1;
                end
            end
        end
    end

    int wr_cnt  = 0;
    int rsp_cnt = 0;
    always @(posedge clk) begin
        if (cam_write_enable) wr_cnt = wr_cnt + 1;
        if (rsp_valid)        rsp_cnt = rsp_cnt + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          op;
        logic [DW-1:0] data;
        logic [MW-1:0] mask;
        logic [1:0]    st;
        logic [AW-1:0] addr;
        int            wr;
        logic          del;
        logic [AW:0]   used;
        logic          fl;
        logic [AW-1:0] waddr;
    } vec_t;

    task automatic do_req(input vec_t v, input int idx);
        int    steps;
        int    wr0;
        string tag;
        tag = $sformatf("v%0d", idx);
        steps = 0;
        while (!req_ready && steps < 40) begin @(negedge clk); steps++; end
        chk({tag, "_ready_timeout"}, (steps < 40), 1);
        wr0 = wr_cnt;
        req_valid = 1'b1; req_op = v.op; req_data = v.data; req_mask = v.mask;
        @(negedge clk);
        req_valid = 1'b0;
        steps = 0;
        while (!rsp_valid && steps < 40) begin @(negedge clk); steps++; end
        chk({tag, "_latency"}, 64'(steps), (v.wr != 0) ? 64'd6 : 64'd2);
        chk({tag, "_status"}, rsp_status, v.st);
        chk({tag, "_addr"}, rsp_addr, v.addr);
        chk({tag, "_wr_cycles"}, 64'(wr_cnt - wr0), 64'(v.wr));
        chk({tag, "_used"}, used_count, v.used);
        chk({tag, "_full"}, full, v.fl);
        chk({tag, "_empty"}, empty, (v.used == 0));
        chk({tag, "_waddr"}, cam_write_addr, v.waddr);
        if (v.wr != 0) begin
            chk({tag, "_wdel"}, cam_write_delete, v.del);
            chk({tag, "_wdata"}, cam_write_data, v.data);
            chk({tag, "_wmask"}, cam_select_mask, v.mask);
        end
        @(negedge clk);
        chk({tag, "_rsp_pulse"}, rsp_valid, 0);
        chk({tag, "_ready_after"}, req_ready, 1);
    endtask

    vec_t vecs [10];
    vec_t v;
    int   rsp0;

    initial begin
        //            op  data     mask  st  addr wr del used full waddr
        vecs[0] = '{1'b0, 16'h000A, 4'hF, 2'd0, 2'd0, 1, 1'b0, 3'd1, 1'b0, 2'd0};
        vecs[1] = '{1'b0, 16'h000A, 4'hF, 2'd2, 2'd0, 0, 1'b0, 3'd1, 1'b0, 2'd0};
        vecs[2] = '{1'b0, 16'h000B, 4'h3, 2'd0, 2'd1, 1, 1'b0, 3'd2, 1'b0, 2'd1};
        vecs[3] = '{1'b0, 16'h000C, 4'h5, 2'd0, 2'd2, 1, 1'b0, 3'd3, 1'b0, 2'd2};
        vecs[4] = '{1'b0, 16'h000D, 4'hF, 2'd0, 2'd3, 1, 1'b0, 3'd4, 1'b1, 2'd3};
        vecs[5] = '{1'b0, 16'h000E, 4'hF, 2'd1, 2'd0, 0, 1'b0, 3'd4, 1'b1, 2'd3};
        vecs[6] = '{1'b1, 16'h000B, 4'hF, 2'd0, 2'd1, 1, 1'b1, 3'd3, 1'b0, 2'd1};
        vecs[7] = '{1'b0, 16'h000F, 4'h9, 2'd0, 2'd1, 1, 1'b0, 3'd4, 1'b1, 2'd1};
        vecs[8] = '{1'b0, 16'h000D, 4'hF, 2'd2, 2'd3, 0, 1'b0, 3'd4, 1'b1, 2'd1};
        vecs[9] = '{1'b1, 16'h0099, 4'hF, 2'd3, 2'd0, 0, 1'b0, 3'd4, 1'b1, 2'd1};

        rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_data = '0; req_mask = '0;
        repeat (3) @(negedge clk);
        chk("rst_used", used_count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_wen", cam_write_enable, 0);
        chk("rst_waddr", cam_write_addr, 0);
        chk("rst_wdata", cam_write_data, 0);
        chk("rst_cmp", cam_compare_data, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", req_ready, 1);

        for (int i = 0; i < 10; i++) do_req(vecs[i], i);

        // Delete of 0xA reaches WAIT, then reset abandons it without a response.
        rsp0 = rsp_cnt;
        req_valid = 1'b1; req_op = 1'b1; req_data = 16'h000A; req_mask = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_wen_seen", cam_write_busy, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_no_rsp", 64'(rsp_cnt - rsp0), 0);
        chk("mid_used", used_count, 0);
        chk("mid_empty", empty, 1);
        chk("mid_full", full, 0);
        chk("mid_ready", req_ready, 1);

        // Bitmap cleared by reset: next insert lands at entry 0 again.
        v = '{1'b0, 16'h0055, 4'h6, 2'd0, 2'd0, 1, 1'b0, 3'd1, 1'b0, 2'd0};
        do_req(v, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/cam_insert_ctrl.md
CAM_INSERT_CTRL -- requirements
Module: cam_insert_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, search/write data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, log2 of CAM entries.
REQ-003 SHALL have parameter SLICE_WIDTH, default 4, CAM slice width; mask width MW = ceil(DATA_WIDTH/SLICE_WIDTH).
REQ-004 SHALL have parameter MATCH_LATENCY, default 1, cycles from compare_data change to valid match result (1..7).
REQ-005 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid&ready.
- req_op  in  1  0 = insert, 1 = delete.
- req_data  in  DATA_WIDTH  key.
- req_mask  in  MW  slice select mask for insert.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_status  out  2  0 OK, 1 FULL, 2 DUP, 3 NOTFOUND.
- rsp_addr  out  ADDR_WIDTH  entry written/deleted, else 0.
- cam_write_addr / cam_write_data / cam_select_mask  out  ADDR_WIDTH / DATA_WIDTH / MW  to CAM write port.
- cam_write_delete, cam_write_enable  out  1  to CAM.
- cam_write_busy  in  1  from CAM.
- cam_compare_data  out  DATA_WIDTH  to CAM search port.
- cam_match  in  1; cam_match_addr  in  ADDR_WIDTH  from CAM.
- used_count  out  ADDR_WIDTH+1  occupied entries.
- full, empty  out  1  used_count == 2**ADDR_WIDTH / == 0.

Function
REQ-006 SHALL keep a 2**ADDR_WIDTH valid bitmap; insert sets bit at written address, delete clears bit at matched address, in the cycle the write is issued.
REQ-007 SHALL use FSM states IDLE, LOOKUP, WRITE, WAIT, RESP.
REQ-008 IDLE: req_ready=1; on req_valid capture op/data/mask, drive cam_compare_data=req_data registered, go LOOKUP; req_ready=0 in all other states.
REQ-009 LOOKUP SHALL last exactly MATCH_LATENCY+1 cycles (counter), sampling cam_match/cam_match_addr in the last cycle only.
REQ-010 Insert decision: match -> RESP status DUP; else full -> RESP status FULL; else WRITE at lowest-index free address.
REQ-011 Delete decision: no match -> RESP status NOTFOUND; else WRITE with cam_write_delete=1 at cam_match_addr.
REQ-012 WRITE SHALL assert cam_write_enable for exactly one cycle with address/data/mask/delete stable, then go WAIT.
REQ-013 WAIT SHALL ignore cam_write_busy in its first cycle, then go RESP on the first cycle cam_write_busy=0.
REQ-014 RESP SHALL pulse rsp_valid one cycle with status/addr, then IDLE; earliest next accept is the cycle after RESP.
REQ-015 used_count SHALL increment on insert WRITE, decrement on delete WRITE, never wrap; full/empty derived combinationally from it.
REQ-016 Rejected requests (DUP, FULL, NOTFOUND) SHALL not touch the CAM write port or bitmap; rsp_addr=0 except DUP, which reports cam_match_addr.
REQ-017 cam outputs SHALL hold previous values outside WRITE except cam_write_enable=0.

Reset
REQ-018 On rst: state IDLE, bitmap all-zero, used_count=0, empty=1, full=0, rsp_valid=0, cam_write_enable=0, all data/address outputs 0; req_ready=1 after rst deasserts.
REQ-019 rst mid-operation SHALL abandon the request with no response; a write already issued to the CAM is not tracked.

Structure
REQ-020 Shared package cam_pkg SHALL hold op encodings, status encodings and FSM state type.
REQ-021 Lowest-free-address search SHALL be sub-module cam_free_enc (bitmap in, addr + none_free out, combinational).

Verification (ADDR_WIDTH=2, MATCH_LATENCY=1, CAM model busy 2 cycles)
REQ-022 Insert 0xA after reset -> rsp OK addr 0, used_count 1, one cam_write_enable pulse, delete=0.
REQ-023 Insert 0xA again -> rsp DUP addr 0, no write pulse, used_count 1.
REQ-024 Insert 0xB,0xC,0xD,0xE -> OK addr 1,2,3 then FULL addr 0; full=1.
REQ-025 Delete 0xB then insert 0xF -> delete OK addr 1 (delete=1), insert OK addr 1; used_count 4.
REQ-026 Delete 0x99 -> NOTFOUND, no write; assert rst during WAIT -> no rsp_valid, used_count 0, req_ready 1.
